alu_seq_ctrl: RTL
=================

// Module: alu_seq_ctrl
// PURPOSE
//  Parametrised ALU micro-sequencer, the next generation of the ALU control FSM.
//  Accepts one ALU instruction per valid/ready handshake and drives one-hot register
//  file enables, ALU operand/result latches, PC increment and a done/err pulse.
//  Adds parametrised register count, a unary-op mode (skips operand B), register
//  index checking, a synchronous abort, and back-to-back issue.
// PARAMETERS
//  NUM_REGS   6        general registers; width of the one-hot rx_out/rx_in buses
//  INSTR_W    16       instruction width; opcode is [INSTR_W-1 -: 4]
//  SEL_W      6        width of each register field; param1 = [2*SEL_W-1:SEL_W], param2 = [SEL_W-1:0]
//  OPC_LO     4'b1000  lowest ALU opcode, inclusive
//  OPC_HI     4'b1110  highest ALU opcode, inclusive
//  UNARY_OPC  4'b1110  opcode that uses param1 only; param2 is ignored
// PORTS
//  clk           in   1         clock, rising edge
//  rst           in   1         asynchronous reset, active-high
//  instr         in   INSTR_W   instruction word; sampled only on accept
//  instr_valid   in   1         instruction present
//  instr_ready   out  1         high only in IDLE; accept = instr_valid & instr_ready & ALU opcode
//  abort         in   1         synchronous abort of the instruction in flight
//  rx_out        out  NUM_REGS  one-hot register-to-bus enable; bit i selects register i
//  rx_in         out  NUM_REGS  one-hot bus-to-register write enable
//  alu_in0       out  1         latch bus into ALU operand A
//  alu_in1       out  1         latch bus into ALU operand B
//  alu_out_latch out  1         latch ALU result
//  alu_out_en    out  1         drive ALU result onto bus
//  pc_inc        out  1         one-cycle PC increment pulse
//  done          out  1         one-cycle completion pulse
//  err           out  1         qualifies done: register index out of range, no write-back
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0 except instr_ready=1. Reset mid-operation aborts
//    immediately with no done.
//  - All outputs are registered Moore functions of state plus the latched instruction.
//  - Opcodes outside OPC_LO..OPC_HI are never accepted: no state change, no outputs,
//    instr_ready stays 1.
//  - On accept: latch opcode, param1, param2. Index check: param1 >= NUM_REGS, or
//    param2 >= NUM_REGS for a non-unary opcode, is an error.
//  - States and outputs (one cycle each, unconditional advance unless noted):
//    IDLE    instr_ready=1; accept -> A_SEL, or ERR on an index error
//    A_SEL   rx_out=onehot(p1), pc_inc=1
//    A_LAT   rx_out=onehot(p1), alu_in0=1; -> EXEC if unary, else B_SEL
//    B_SEL   rx_out=onehot(p2)
//    B_LAT   rx_out=onehot(p2), alu_in1=1
//    EXEC    alu_out_latch=1
//    DRV     alu_out_en=1
//    WB      alu_out_en=1, rx_in=onehot(p1)
//    DONE    done=1; -> IDLE
//    ERR     pc_inc=1; -> DONE with err=1; no enables asserted
//  - Latency from the accept edge to the done pulse: binary 8 cycles; unary 6; error 2.
//    Next accept is possible on the cycle after DONE.
//  - Bus safety: rx_out is never nonzero while alu_out_en=1. rx_in and rx_out are each
//    one-hot or zero.
//  - abort=1 in any non-IDLE state: the next state is IDLE, all outputs 0, no done. A write
//    already issued in WB is not undone. abort in IDLE is ignored.
//  - instr changing after accept has no effect on the operation in flight.
// TESTING
//  1 rst mid-op in B_LAT -> all outputs 0 and instr_ready=1 immediately, asynchronously.
//  2 instr=16'h8043 (opc 8, p1=1, p2=3) -> pc_inc on cycle 1; rx_out=6'b000010 in cycles 1-2;
//    rx_out=6'b001000 in cycles 3-4; rx_in=6'b000010 in cycle 7; done in cycle 8; err=0.
//  3 instr=16'hE080 (unary, p1=2) -> B_SEL/B_LAT skipped; alu_in1 never high; done in cycle 6.
//  4 instr=16'h8007 (p2=7, NUM_REGS=6) -> pc_inc in cycle 1; done=1 with err=1 in cycle 2;
//    rx_in/rx_out stay 0.
//  5 instr=16'h3041 (non-ALU) -> not accepted, all outputs 0; then back-to-back ALU
//    instructions -> second accepted on the cycle after DONE.
//  6 abort asserted in EXEC -> IDLE next cycle; done never pulses; alu_out_en never high.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: ALU micro-sequencer, one instruction per valid/ready handshake.
// Latency: accept edge to done pulse is 8 cycles (binary), 6 (unary), 2 (index error).
// Backpressure: instr_ready is high only in IDLE; abort returns to IDLE next cycle.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   instr, instr_valid       instruction word and its valid; instr_ready high only in IDLE
//   abort                    synchronous abort of the instruction in flight
//   rx_out / rx_in           one-hot register-to-bus / bus-to-register enables
//   alu_in0, alu_in1         latch bus into ALU operand A / B
//   alu_out_latch, alu_out_en latch ALU result / drive it onto the bus
//   pc_inc, done, err        PC increment pulse, completion pulse, error qualifier on done
module alu_seq_ctrl #(
   parameter int         NUM_REGS  = 6,
   parameter int         INSTR_W   = 16,
   parameter int         SEL_W     = 6,
   parameter logic [3:0] OPC_LO    = 4'b1000,
   parameter logic [3:0] OPC_HI    = 4'b1110,
   parameter logic [3:0] UNARY_OPC = 4'b1110
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [INSTR_W-1:0]  instr,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic                abort,
   output logic [NUM_REGS-1:0] rx_out,
   output logic [NUM_REGS-1:0] rx_in,
   output logic                alu_in0,
   output logic                alu_in1,
   output logic                alu_out_latch,
   output logic                alu_out_en,
   output logic                pc_inc,
   output logic                done,
   output logic                err
);

   typedef enum logic [3:0] {
      S_IDLE, S_A_SEL, S_A_LAT, S_B_SEL, S_B_LAT,
      S_EXEC, S_DRV, S_WB, S_DONE, S_ERR
   } state_t;

   typedef struct packed {
      logic                ready;
      logic [NUM_REGS-1:0] rxo;
      logic [NUM_REGS-1:0] rxi;
      logic                in0;
      logic                in1;
      logic                lat;
      logic                en;
      logic                pc;
      logic                dn;
      logic                er;
   } outs_t;

   state_t             state, state_n;
   logic [SEL_W-1:0]   p1_q, p2_q, p1_n, p2_n;
   logic               unary_q, err_q, unary_n, err_n;
   logic [3:0]         opc;
   logic [SEL_W-1:0]   p1, p2;
   logic               is_alu, is_unary, idx_err, accept;
   outs_t              outs_q, outs_n;

   function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [NUM_REGS-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_REGS; i++) v[i] = (idx == SEL_W'(i));
      return v;
   endfunction

   // Output word for a given state; registered so every output is a clean flop.
   function automatic outs_t decode(input state_t s, input logic [SEL_W-1:0] a,
                                    input logic [SEL_W-1:0] b, input logic e);
      outs_t o;
      o = '0;
      case (s)
         S_IDLE:  o.ready = 1'b1;
         S_A_SEL: begin o.rxo = onehot(a); o.pc  = 1'b1; end
         S_A_LAT: begin o.rxo = onehot(a); o.in0 = 1'b1; end
         S_B_SEL: o.rxo = onehot(b);
         S_B_LAT: begin o.rxo = onehot(b); o.in1 = 1'b1; end
         S_EXEC:  o.lat = 1'b1;
         S_DRV:   o.en  = 1'b1;
         S_WB:    begin o.en = 1'b1; o.rxi = onehot(a); end
         S_DONE:  begin o.dn = 1'b1; o.er = e; end
         S_ERR:   o.pc = 1'b1;
         default: o = '0;
      endcase
      return o;
   endfunction

   always_comb begin
      opc      = instr[INSTR_W-1 -: 4];
      p1       = instr[2*SEL_W-1:SEL_W];
      p2       = instr[SEL_W-1:0];
      is_alu   = (opc >= OPC_LO) && (opc <= OPC_HI);
      is_unary = (opc == UNARY_OPC);
      idx_err  = ({{(32-SEL_W){1'b0}}, p1} >= NUM_REGS) ||
                 (!is_unary && ({{(32-SEL_W){1'b0}}, p2} >= NUM_REGS));
      accept   = (state == S_IDLE) && instr_valid && is_alu;
   end

   always_comb begin
      state_n = state;
      p1_n    = p1_q;
      p2_n    = p2_q;
      unary_n = unary_q;
      err_n   = err_q;
      if (state != S_IDLE && abort) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               p1_n    = p1;
               p2_n    = p2;
               unary_n = is_unary;
               err_n   = idx_err;
               state_n = idx_err ? S_ERR : S_A_SEL;
            end
            S_A_SEL: state_n = S_A_LAT;
            S_A_LAT: state_n = unary_q ? S_EXEC : S_B_SEL;
            S_B_SEL: state_n = S_B_LAT;
            S_B_LAT: state_n = S_EXEC;
            S_EXEC:  state_n = S_DRV;
            S_DRV:   state_n = S_WB;
            S_WB:    state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_DONE;
            default: state_n = S_IDLE;
         endcase
      end
      outs_n = decode(state_n, p1_n, p2_n, err_n);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         p1_q    <= '0;
         p2_q    <= '0;
         unary_q <= 1'b0;
         err_q   <= 1'b0;
         outs_q  <= '{ready: 1'b1, default: '0};
      end else begin
         state   <= state_n;
         p1_q    <= p1_n;
         p2_q    <= p2_n;
         unary_q <= unary_n;
         err_q   <= err_n;
         outs_q  <= outs_n;
      end
   end

   assign instr_ready   = outs_q.ready;
   assign rx_out        = outs_q.rxo;
   assign rx_in         = outs_q.rxi;
   assign alu_in0       = outs_q.in0;
   assign alu_in1       = outs_q.in1;
   assign alu_out_latch = outs_q.lat;
   assign alu_out_en    = outs_q.en;
   assign pc_inc        = outs_q.pc;
   assign done          = outs_q.dn;
   assign err           = outs_q.er;

endmodule
